// File: rtl/axi4_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | axi4_pkg : shared AXI4 encodings, native memop codes, bridge FSM   |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
package axi4_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] SIZE_4B     = 3'b010;
  localparam logic [3:0] CACHE_MODIFIABLE_BUF = 4'b0011;
  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  // memop is {read, write}; swap performs the read first
  localparam logic [1:0] MEMOP_IDLE  = 2'b00;
  localparam logic [1:0] MEMOP_WRITE = 2'b01;
  localparam logic [1:0] MEMOP_READ  = 2'b10;
  localparam logic [1:0] MEMOP_SWAP  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RADDR = 3'd1,
    ST_RDATA = 3'd2,
    ST_WREQ  = 3'd3,
    ST_WRESP = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/axi4_master_bridge_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | axi4_master_bridge_if : AXI4 channel bundle, master/slave views    |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
interface axi4_master_bridge_if #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [ID_WIDTH-1:0]     ARID;
  logic [7:0]              ARLEN;
  logic [2:0]              ARSIZE;
  logic [1:0]              ARBURST;
  logic                    ARLOCK;
  logic [3:0]              ARCACHE;
  logic [2:0]              ARPROT;

  logic [DATA_WIDTH-1:0]   RDATA;
  logic                    RVALID;
  logic                    RREADY;
  logic [1:0]              RRESP;
  logic [ID_WIDTH-1:0]     RID;
  logic                    RLAST;

  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [ID_WIDTH-1:0]     AWID;
  logic [7:0]              AWLEN;
  logic [2:0]              AWSIZE;
  logic [1:0]              AWBURST;
  logic                    AWLOCK;
  logic [3:0]              AWCACHE;
  logic [2:0]              AWPROT;

  logic [DATA_WIDTH-1:0]   WDATA;
  logic                    WVALID;
  logic                    WREADY;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WLAST;

  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;
  logic [ID_WIDTH-1:0]     BID;

  modport master (
    output ARADDR, ARVALID, ARID, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT,
    input  ARREADY,
    input  RDATA, RVALID, RRESP, RID, RLAST,
    output RREADY,
    output AWADDR, AWVALID, AWID, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT,
    input  AWREADY,
    output WDATA, WVALID, WSTRB, WLAST,
    input  WREADY,
    input  BRESP, BVALID, BID,
    output BREADY
  );

  modport slave (
    input  ARADDR, ARVALID, ARID, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT,
    output ARREADY,
    output RDATA, RVALID, RRESP, RID, RLAST,
    input  RREADY,
    input  AWADDR, AWVALID, AWID, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT,
    output AWREADY,
    input  WDATA, WVALID, WSTRB, WLAST,
    output WREADY,
    output BRESP, BVALID, BID,
    input  BREADY
  );

endinterface
`default_nettype wire

// File: rtl/axi4_master_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | axi4_master_bridge : native single-word memop -> single-beat AXI4  |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module axi4_master_bridge
  import axi4_pkg::*;
#(
  parameter int                            C_M_AXI_ID_WIDTH   = 4,
  parameter int                            C_M_AXI_ADDR_WIDTH = 32,
  parameter int                            C_M_AXI_DATA_WIDTH = 32,
  parameter logic [C_M_AXI_ID_WIDTH-1:0]   C_M_AXI_ID         = '0,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_M_AXI_BASEADDR   = '0
) (
  input  logic                          M_AXI_ACLK,
  input  logic                          M_AXI_ARESETN,
  input  logic [1:0]                    memop,
  input  logic [C_M_AXI_ADDR_WIDTH-3:0] memaddr,
  input  logic [31:0]                   memdatain,
  input  logic [3:0]                    membyteselect,
  input  logic                          memlock,
  output logic [31:0]                   memdataout,
  output logic                          memrdy,
  output logic                          memerr,
  output logic                          memexfail,
  axi4_master_bridge_if.master          m_axi
);

  if (C_M_AXI_DATA_WIDTH != 32) begin : g_bad_data_width
    $error("axi4_master_bridge supports only a 32-bit data path");
  end

  state_t                        r_state;
  logic [C_M_AXI_ADDR_WIDTH-1:0] r_addr;
  logic [31:0]                   r_wdata;
  logic [3:0]                    r_wstrb;
  logic                          r_lock;
  logic                          r_swap;
  logic                          r_arvalid, r_rready, r_awvalid, r_wvalid, r_bready;
  logic                          r_aw_done, r_w_done;
  logic [31:0]                   r_dataout;
  logic                          r_err, r_exfail;

  logic [C_M_AXI_ADDR_WIDTH-1:0] w_accept_addr;
  logic                          w_aw_hs, w_w_hs, w_aw_fin, w_w_fin;
  logic                          w_unused_ok;

  assign w_accept_addr = {memaddr, 2'b00} + C_M_AXI_BASEADDR;
  assign w_aw_hs       = r_awvalid & m_axi.AWREADY;
  assign w_w_hs        = r_wvalid & m_axi.WREADY;
  // AW and W retire independently; each counts as finished once its flag is set or it handshakes now
  assign w_aw_fin      = r_aw_done | w_aw_hs;
  assign w_w_fin       = r_w_done | w_w_hs;
  assign w_unused_ok   = ^{m_axi.RID, m_axi.BID, m_axi.RLAST, m_axi.RRESP[0]};

  assign memrdy     = (r_state == ST_IDLE) & M_AXI_ARESETN;
  assign memdataout = r_dataout;
  assign memerr     = r_err;
  assign memexfail  = r_exfail;

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_lock    <= 1'b0;
      r_swap    <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_dataout <= '0;
      r_err     <= 1'b0;
      r_exfail  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (memop != MEMOP_IDLE) begin
            r_addr   <= w_accept_addr;
            r_wdata  <= memdatain;
            r_wstrb  <= membyteselect;
            r_lock   <= memlock;
            r_swap   <= (memop == MEMOP_SWAP);
            r_err    <= 1'b0;
            r_exfail <= 1'b0;
            if (memop[1]) begin
              r_state   <= ST_RADDR;
              r_arvalid <= 1'b1;
            end else begin
              r_state   <= ST_WREQ;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_aw_done <= 1'b0;
              r_w_done  <= 1'b0;
            end
          end
        end
        ST_RADDR: begin
          if (m_axi.ARREADY) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= ST_RDATA;
          end
        end
        ST_RDATA: begin
          if (m_axi.RVALID) begin
            r_rready  <= 1'b0;
            r_dataout <= m_axi.RDATA;
            r_err     <= r_err | m_axi.RRESP[1];
            if (r_swap) begin
              r_state   <= ST_WREQ;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_aw_done <= 1'b0;
              r_w_done  <= 1'b0;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_WREQ: begin
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_hs) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          if (w_aw_fin && w_w_fin) begin
            r_state  <= ST_WRESP;
            r_bready <= 1'b1;
          end
        end
        ST_WRESP: begin
          if (m_axi.BVALID) begin
            r_bready <= 1'b0;
            r_err    <= r_err | m_axi.BRESP[1];
            // an exclusive write answered with plain OKAY means the monitor was lost
            r_exfail <= r_lock & (m_axi.BRESP == RESP_OKAY);
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign m_axi.ARADDR  = r_addr;
  assign m_axi.ARVALID = r_arvalid;
  assign m_axi.ARID    = C_M_AXI_ID;
  assign m_axi.ARLEN   = 8'd0;
  assign m_axi.ARSIZE  = SIZE_4B;
  assign m_axi.ARBURST = BURST_INCR;
  assign m_axi.ARLOCK  = r_lock;
  assign m_axi.ARCACHE = CACHE_MODIFIABLE_BUF;
  assign m_axi.ARPROT  = PROT_DEFAULT;
  assign m_axi.RREADY  = r_rready;

  assign m_axi.AWADDR  = r_addr;
  assign m_axi.AWVALID = r_awvalid;
  assign m_axi.AWID    = C_M_AXI_ID;
  assign m_axi.AWLEN   = 8'd0;
  assign m_axi.AWSIZE  = SIZE_4B;
  assign m_axi.AWBURST = BURST_INCR;
  assign m_axi.AWLOCK  = r_lock;
  assign m_axi.AWCACHE = CACHE_MODIFIABLE_BUF;
  assign m_axi.AWPROT  = PROT_DEFAULT;

  assign m_axi.WDATA   = r_wdata;
  assign m_axi.WVALID  = r_wvalid;
  assign m_axi.WSTRB   = r_wstrb;
  assign m_axi.WLAST   = 1'b1;
  assign m_axi.BREADY  = r_bready;

endmodule
`default_nettype wire

// File: tb/tb_axi4_master_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_axi4_master_bridge : directed + random-backpressure bench       |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module tb_axi4_master_bridge;
  import axi4_pkg::*;

  localparam int          IDW  = 4;
  localparam int          AW   = 32;
  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  memop = 2'b00;
  logic [29:0] memaddr = '0;
  logic [31:0] memdatain = '0;
  logic [3:0]  membyteselect = '0;
  logic        memlock = 1'b0;
  logic [31:0] memdataout;
  logic        memrdy, memerr, memexfail;

  axi4_master_bridge_if #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(32)) m_axi ();

  axi4_master_bridge #(
    .C_M_AXI_ID_WIDTH  (IDW),
    .C_M_AXI_ADDR_WIDTH(AW),
    .C_M_AXI_DATA_WIDTH(32),
    .C_M_AXI_ID        (4'h0),
    .C_M_AXI_BASEADDR  (BASE)
  ) dut (
    .M_AXI_ACLK   (clk),
    .M_AXI_ARESETN(rst_n),
    .memop        (memop),
    .memaddr      (memaddr),
    .memdatain    (memdatain),
    .membyteselect(membyteselect),
    .memlock      (memlock),
    .memdataout   (memdataout),
    .memrdy       (memrdy),
    .memerr       (memerr),
    .memexfail    (memexfail),
    .m_axi        (m_axi)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int valid_drops = 0;

  int ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
  logic [1:0] r_resp = RESP_OKAY;
  logic [1:0] b_resp = RESP_OKAY;

  logic [31:0] slave_mem [logic [31:0]];
  logic [31:0] model_mem [logic [31:0]];

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  function automatic logic [31:0] slave_rd(input logic [31:0] a);
    return slave_mem.exists(a) ? slave_mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // Reactive AXI slave with programmable per-channel wait states; also flags VALIDs dropped early
  initial begin : slave
    bit ar_hs, r_hs, aw_hs, w_hs, b_hs;
    bit rd_pend, aw_got, w_got, b_pend;
    bit p_arv, p_awv, p_wv;
    logic [31:0] rd_addr, wr_addr, wr_data;
    logic [3:0]  wr_strb;
    int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    m_axi.ARREADY = 0; m_axi.RVALID = 0; m_axi.RDATA = '0; m_axi.RRESP = '0;
    m_axi.RID = '0; m_axi.RLAST = 1'b1; m_axi.AWREADY = 0; m_axi.WREADY = 0;
    m_axi.BVALID = 0; m_axi.BRESP = '0; m_axi.BID = '0;
    rd_pend = 0; aw_got = 0; w_got = 0; b_pend = 0; p_arv = 0; p_awv = 0; p_wv = 0;
    ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    rd_addr = '0; wr_addr = '0; wr_data = '0; wr_strb = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_axi.ARREADY = 0; m_axi.RVALID = 0; m_axi.AWREADY = 0; m_axi.WREADY = 0; m_axi.BVALID = 0;
        rd_pend = 0; aw_got = 0; w_got = 0; b_pend = 0; p_arv = 0; p_awv = 0; p_wv = 0;
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        continue;
      end
      ar_hs = m_axi.ARREADY; r_hs = m_axi.RVALID; aw_hs = m_axi.AWREADY;
      w_hs = m_axi.WREADY; b_hs = m_axi.BVALID;
      if (p_arv && !ar_hs && !m_axi.ARVALID) valid_drops++;
      if (p_awv && !aw_hs && !m_axi.AWVALID) valid_drops++;
      if (p_wv && !w_hs && !m_axi.WVALID) valid_drops++;
      m_axi.ARREADY = 0; m_axi.RVALID = 0; m_axi.AWREADY = 0; m_axi.WREADY = 0; m_axi.BVALID = 0;
      if (ar_hs) begin rd_pend = 1; r_cnt = 0; end
      if (aw_hs) aw_got = 1;
      if (w_hs) w_got = 1;
      if (aw_got && w_got) begin
        slave_mem[wr_addr] = merge(slave_rd(wr_addr), wr_data, wr_strb);
        aw_got = 0; w_got = 0; b_pend = 1; b_cnt = 0;
      end
      if (!ar_hs && m_axi.ARVALID) begin
        if (ar_cnt >= ar_delay) begin m_axi.ARREADY = 1; rd_addr = m_axi.ARADDR; ar_cnt = 0; end
        else ar_cnt++;
      end
      if (rd_pend && m_axi.RREADY) begin
        if (r_cnt >= r_delay) begin
          m_axi.RVALID = 1; m_axi.RDATA = slave_rd(rd_addr); m_axi.RRESP = r_resp; rd_pend = 0;
        end else r_cnt++;
      end
      if (!aw_hs && !aw_got && m_axi.AWVALID) begin
        if (aw_cnt >= aw_delay) begin m_axi.AWREADY = 1; wr_addr = m_axi.AWADDR; aw_cnt = 0; end
        else aw_cnt++;
      end
      if (!w_hs && !w_got && m_axi.WVALID) begin
        if (w_cnt >= w_delay) begin
          m_axi.WREADY = 1; wr_data = m_axi.WDATA; wr_strb = m_axi.WSTRB; w_cnt = 0;
        end else w_cnt++;
      end
      if (b_pend && m_axi.BREADY) begin
        if (b_cnt >= b_delay) begin m_axi.BVALID = 1; m_axi.BRESP = b_resp; b_pend = 0; end
        else b_cnt++;
      end
      p_arv = m_axi.ARVALID; p_awv = m_axi.AWVALID; p_wv = m_axi.WVALID;
    end
  end

  // Presents a request at a negedge once memrdy is seen; returns just after the accept edge
  task automatic issue(input logic [1:0] op, input logic [29:0] a, input logic [31:0] d,
                       input logic [3:0] bs, input logic lk);
    int n;
    n = 0;
    @(negedge clk);
    while (!memrdy && n < 300) begin @(negedge clk); n++; end
    tests_run++;
    if (memrdy !== 1'b1) begin
      tests_failed++;
      $display("FAIL issue_wait: memrdy=%b required 1 within 300 cycles", memrdy);
    end
    memop = op; memaddr = a; memdatain = d; membyteselect = bs; memlock = lk;
    @(posedge clk);
    #1 memop = MEMOP_IDLE;
  endtask

  task automatic wait_rdy();
    int n;
    n = 0;
    while (!memrdy && n < 300) begin @(negedge clk); n++; end
    tests_run++;
    if (memrdy !== 1'b1) begin
      tests_failed++;
      $display("FAIL completion_wait: memrdy=%b required 1 within 300 cycles", memrdy);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests_run++;
    if ({m_axi.ARVALID, m_axi.RREADY, m_axi.AWVALID, m_axi.WVALID, m_axi.BREADY} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_handshakes: got %b required 00000",
               {m_axi.ARVALID, m_axi.RREADY, m_axi.AWVALID, m_axi.WVALID, m_axi.BREADY});
    end
    tests_run++;
    if ({memdataout, memerr, memexfail, memrdy} !== 35'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: dataout=%h err=%b exfail=%b rdy=%b required all 0",
               memdataout, memerr, memexfail, memrdy);
    end
    #2 rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (memrdy !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_release_rdy: got %b required 1", memrdy);
    end
  endtask

  task automatic test_read();
    slave_mem[32'h4000_0400] = 32'hDEAD_BEEF;
    model_mem[32'h4000_0400] = 32'hDEAD_BEEF;
    issue(MEMOP_READ, 30'h100, 32'h0, 4'h0, 1'b0);
    @(negedge clk);
    tests_run++;
    if ({m_axi.ARVALID, m_axi.ARADDR} !== {1'b1, 32'h4000_0400}) begin
      tests_failed++;
      $display("FAIL read_ar: valid=%b addr=%h required 1 40000400", m_axi.ARVALID, m_axi.ARADDR);
    end
    tests_run++;
    if ({m_axi.ARLEN, m_axi.ARSIZE, m_axi.ARBURST, m_axi.ARCACHE, m_axi.ARPROT, m_axi.ARLOCK}
        !== {8'd0, 3'b010, 2'b01, 4'b0011, 3'b000, 1'b0}) begin
      tests_failed++;
      $display("FAIL read_ar_fields: len=%h size=%b burst=%b cache=%b prot=%b lock=%b required 00 010 01 0011 000 0",
               m_axi.ARLEN, m_axi.ARSIZE, m_axi.ARBURST, m_axi.ARCACHE, m_axi.ARPROT, m_axi.ARLOCK);
    end
    @(negedge clk);
    tests_run++;
    if ({m_axi.RREADY, m_axi.ARVALID, memrdy} !== 3'b100) begin
      tests_failed++;
      $display("FAIL read_rready: rready/arvalid/rdy=%b required 100", {m_axi.RREADY, m_axi.ARVALID, memrdy});
    end
    @(negedge clk);
    tests_run++;
    if ({memrdy, memdataout, memerr} !== {1'b1, 32'hDEAD_BEEF, 1'b0}) begin
      tests_failed++;
      $display("FAIL read_done: rdy=%b data=%h err=%b required 1 deadbeef 0", memrdy, memdataout, memerr);
    end
  endtask

  task automatic test_write_split();
    aw_delay = 2; w_delay = 0;
    issue(MEMOP_WRITE, 30'h20, 32'h1122_3344, 4'b0110, 1'b0);
    @(negedge clk);
    tests_run++;
    if ({m_axi.AWVALID, m_axi.WVALID, m_axi.WSTRB, m_axi.WLAST, m_axi.AWADDR}
        !== {2'b11, 4'b0110, 1'b1, 32'h4000_0080}) begin
      tests_failed++;
      $display("FAIL write_start: aw/w=%b strb=%b last=%b addr=%h required 11 0110 1 40000080",
               {m_axi.AWVALID, m_axi.WVALID}, m_axi.WSTRB, m_axi.WLAST, m_axi.AWADDR);
    end
    @(negedge clk);
    tests_run++;
    if ({m_axi.AWVALID, m_axi.WVALID} !== 2'b10) begin
      tests_failed++;
      $display("FAIL write_w_first: aw/w=%b required 10", {m_axi.AWVALID, m_axi.WVALID});
    end
    @(negedge clk);
    tests_run++;
    if ({m_axi.AWVALID, m_axi.WVALID, m_axi.BREADY} !== 3'b100) begin
      tests_failed++;
      $display("FAIL write_aw_wait: aw/w/bready=%b required 100", {m_axi.AWVALID, m_axi.WVALID, m_axi.BREADY});
    end
    @(negedge clk);
    tests_run++;
    if ({m_axi.AWVALID, m_axi.WVALID, m_axi.BREADY, memrdy} !== 4'b0010) begin
      tests_failed++;
      $display("FAIL write_bready: aw/w/bready/rdy=%b required 0010",
               {m_axi.AWVALID, m_axi.WVALID, m_axi.BREADY, memrdy});
    end
    @(negedge clk);
    tests_run++;
    if ({memrdy, m_axi.BREADY} !== 2'b10) begin
      tests_failed++;
      $display("FAIL write_done: rdy/bready=%b required 10", {memrdy, m_axi.BREADY});
    end
    tests_run++;
    if (slave_rd(32'h4000_0080) !== 32'hE522_33DA) begin
      tests_failed++;
      $display("FAIL write_strobe_merge: mem=%h required e52233da", slave_rd(32'h4000_0080));
    end
    aw_delay = 0;
  endtask

  task automatic test_swap();
    slave_mem[32'h4000_0040] = 32'h1234_5678;
    model_mem[32'h4000_0040] = 32'h1234_5678;
    issue(MEMOP_SWAP, 30'h10, 32'hCAFE_F00D, 4'hF, 1'b0);
    @(negedge clk);
    tests_run++;
    if ({m_axi.ARVALID, m_axi.AWVALID, m_axi.WVALID} !== 3'b100) begin
      tests_failed++;
      $display("FAIL swap_ar: ar/aw/w=%b required 100", {m_axi.ARVALID, m_axi.AWVALID, m_axi.WVALID});
    end
    @(negedge clk);
    tests_run++;
    if ({m_axi.RREADY, m_axi.AWVALID} !== 2'b10) begin
      tests_failed++;
      $display("FAIL swap_r: rready/awvalid=%b required 10", {m_axi.RREADY, m_axi.AWVALID});
    end
    @(negedge clk);
    tests_run++;
    if ({m_axi.AWVALID, m_axi.WVALID, m_axi.WDATA, memdataout}
        !== {2'b11, 32'hCAFE_F00D, 32'h1234_5678}) begin
      tests_failed++;
      $display("FAIL swap_w: aw/w=%b wdata=%h dataout=%h required 11 cafef00d 12345678",
               {m_axi.AWVALID, m_axi.WVALID}, m_axi.WDATA, memdataout);
    end
    @(negedge clk);
    tests_run++;
    if ({memrdy, m_axi.BREADY} !== 2'b01) begin
      tests_failed++;
      $display("FAIL swap_b: rdy/bready=%b required 01", {memrdy, m_axi.BREADY});
    end
    @(negedge clk);
    tests_run++;
    if ({memrdy, memdataout, slave_rd(32'h4000_0040)} !== {1'b1, 32'h1234_5678, 32'hCAFE_F00D}) begin
      tests_failed++;
      $display("FAIL swap_done: rdy=%b data=%h mem=%h required 1 12345678 cafef00d",
               memrdy, memdataout, slave_rd(32'h4000_0040));
    end
  endtask

  task automatic test_errors();
    r_resp = RESP_SLVERR;
    issue(MEMOP_READ, 30'h5, 32'h0, 4'h0, 1'b0);
    wait_rdy();
    repeat (3) @(negedge clk);
    tests_run++;
    if ({memerr, memexfail} !== 2'b10) begin
      tests_failed++;
      $display("FAIL slverr_hold: err/exfail=%b required 10", {memerr, memexfail});
    end
    r_resp = RESP_OKAY;
    b_resp = RESP_OKAY;
    issue(MEMOP_WRITE, 30'h30, 32'hAAAA_5555, 4'hF, 1'b1);
    @(negedge clk);
    tests_run++;
    if ({memerr, m_axi.AWLOCK} !== 2'b01) begin
      tests_failed++;
      $display("FAIL lock_accept: err/awlock=%b required 01", {memerr, m_axi.AWLOCK});
    end
    wait_rdy();
    tests_run++;
    if ({memerr, memexfail} !== 2'b01) begin
      tests_failed++;
      $display("FAIL exfail_okay: err/exfail=%b required 01", {memerr, memexfail});
    end
    b_resp = RESP_EXOKAY;
    issue(MEMOP_WRITE, 30'h31, 32'h5555_AAAA, 4'hF, 1'b1);
    wait_rdy();
    tests_run++;
    if ({memerr, memexfail} !== 2'b00) begin
      tests_failed++;
      $display("FAIL exokay: err/exfail=%b required 00", {memerr, memexfail});
    end
    b_resp = RESP_DECERR;
    issue(MEMOP_WRITE, 30'h32, 32'h0, 4'hF, 1'b0);
    wait_rdy();
    tests_run++;
    if ({memerr, memexfail} !== 2'b10) begin
      tests_failed++;
      $display("FAIL decerr_write: err/exfail=%b required 10", {memerr, memexfail});
    end
    b_resp = RESP_OKAY;
  endtask

  task automatic test_reset_mid();
    r_delay = 1000;
    issue(MEMOP_READ, 30'h7, 32'h0, 4'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (m_axi.RREADY !== 1'b1) begin
      tests_failed++;
      $display("FAIL midreset_in_rdata: rready=%b required 1", m_axi.RREADY);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({m_axi.RREADY, memrdy, m_axi.ARVALID} !== 3'b000) begin
      tests_failed++;
      $display("FAIL midreset_async: rready/rdy/arvalid=%b required 000", {m_axi.RREADY, memrdy, m_axi.ARVALID});
    end
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    r_delay = 0;
    @(negedge clk);
    tests_run++;
    if (memrdy !== 1'b1) begin
      tests_failed++;
      $display("FAIL midreset_release: rdy=%b required 1", memrdy);
    end
    issue(MEMOP_READ, 30'h7, 32'h0, 4'h0, 1'b0);
    wait_rdy();
    tests_run++;
    if ({memdataout, memerr} !== {32'hE5A5_5A46, 1'b0}) begin
      tests_failed++;
      $display("FAIL midreset_reread: data=%h err=%b required e5a55a46 0", memdataout, memerr);
    end
  endtask

  task automatic test_random_backpressure();
    logic [1:0]  op;
    logic [29:0] a;
    logic [31:0] d, ba, exp_rd;
    logic [3:0]  bs;
    for (int k = 0; k < 1000; k++) begin
      ar_delay = $urandom_range(0, 3); r_delay = $urandom_range(0, 3);
      aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3);
      b_delay  = $urandom_range(0, 3);
      op = 2'($urandom_range(1, 3));
      a  = 30'($urandom_range(0, 15));
      d  = $urandom;
      bs = 4'($urandom_range(0, 15));
      ba = BASE + {a, 2'b00};
      exp_rd = model_rd(ba);
      if (op[0]) model_mem[ba] = merge(exp_rd, d, bs);
      issue(op, a, d, bs, 1'b0);
      wait_rdy();
      if (op[1]) begin
        tests_run++;
        if (memdataout !== exp_rd) begin
          tests_failed++;
          $display("FAIL rand_read op%0d addr=%h: data=%h required %h", k, ba, memdataout, exp_rd);
        end
      end
    end
    for (int j = 0; j < 16; j++) begin
      tests_run++;
      if (slave_rd(BASE + 32'(j * 4)) !== model_rd(BASE + 32'(j * 4))) begin
        tests_failed++;
        $display("FAIL rand_final_mem word%0d: mem=%h required %h", j,
                 slave_rd(BASE + 32'(j * 4)), model_rd(BASE + 32'(j * 4)));
      end
    end
    tests_run++;
    if (valid_drops !== 0) begin
      tests_failed++;
      $display("FAIL valid_held: %0d early VALID drops, required 0", valid_drops);
    end
    ar_delay = 0; r_delay = 0; aw_delay = 0; w_delay = 0; b_delay = 0;
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_split();
    test_swap();
    test_errors();
    test_reset_mid();
    test_random_backpressure();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
